// File: rtl/proc_control_unit.sv
// Control unit for a simple 9-bit multi-cycle processor.
// Decodes mv / mvi / add / sub from a latched instruction register and sequences
// the bus-source selects and register load enables over states T0..T3.
//
// Run/Done protocol: Run is a request that is sampled only on a fetch edge,
// which is the edge leaving T0 or the edge leaving the final (Done) cycle of an
// instruction. On a fetch edge with Run=1, DIN is captured into IR and T1 is
// entered. Run at any other edge is ignored, so a request there is neither
// queued nor able to abort the instruction in flight. Done pulses for exactly
// one cycle in the last cycle of every instruction. Because that cycle doubles
// as the T0 fetch slot, Run held high chains instructions with no idle cycle.
module proc_control_unit (
  input  logic       Clock,
  input  logic       rst,
  input  logic       Run,
  input  logic [8:0] DIN,
  output logic       R0out,
  output logic       R1out,
  output logic       R2out,
  output logic       R3out,
  output logic       R4out,
  output logic       R5out,
  output logic       R6out,
  output logic       R7out,
  output logic       Gout,
  output logic       DINout,
  output logic       R0in,
  output logic       R1in,
  output logic       R2in,
  output logic       R3in,
  output logic       R4in,
  output logic       R5in,
  output logic       R6in,
  output logic       R7in,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done,
  output logic       Busy,
  output logic       Err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  logic [7:0] r_out;
  logic [7:0] r_in;
  logic       g_out;
  logic       din_out;
  logic       a_in;
  logic       g_in;
  logic       add_sub;
  logic       done;
  logic       err;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // State and instruction register; reset abandons any instruction at once.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state_q <= T0;
      ir_q    <= 9'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore decode of selects/enables from state and IR only.
  always_comb begin
    r_out   = 8'b0;
    r_in    = 8'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      T1: begin
        case (op)
          OP_MV: begin
            r_out[ry] = 1'b1;
            r_in[rx]  = 1'b1;
            done      = 1'b1;
          end
          OP_MVI: begin
            din_out   = 1'b1;
            r_in[rx]  = 1'b1;
            done      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            r_out[rx] = 1'b1;
            a_in      = 1'b1;
          end
          default: begin
            // Illegal opcode: complete immediately, touch nothing.
            done = 1'b1;
            err  = 1'b1;
          end
        endcase
      end
      T2: begin
        r_out[ry] = 1'b1;
        g_in      = 1'b1;
        add_sub   = op[0];
      end
      T3: begin
        g_out    = 1'b1;
        r_in[rx] = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Next state: fetch on T0 or on the final cycle of an instruction, else step.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if ((state_q == T0) || done) begin
      if (Run) begin
        ir_d    = DIN;
        state_d = T1;
      end else begin
        state_d = T0;
      end
    end else begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        default: state_d = T0;
      endcase
    end
  end

  assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = r_out;
  assign {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in}         = r_in;
  assign Gout      = g_out;
  assign DINout    = din_out;
  assign Ain       = a_in;
  assign Gin       = g_in;
  assign AddSub    = add_sub;
  assign Done      = done;
  assign Err       = err;
  assign Busy      = (state_q != T0);
  assign dbg_state = state_q;

endmodule
